// File: rtl/io_pkg.sv
// io_pkg: shared constants and FSM encoding for the IO bus controller.
//   IO_REGION     - cpu_addr[15:14] value that selects the IO region
//   LOC_BASE      - cpu_addr[15:4] value of the local register window
//   STAT_ADDR     - status register (io_err in bit 15)
//   ERRADDR_ADDR  - captured error address (only with IO_ERR_CAPTURE_EN)
//   TIMEOUT_DATA  - read data returned for a timed-out access
package io_pkg;

    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [11:0] LOC_BASE     = 12'hFFF;
    localparam logic [15:0] STAT_ADDR    = 16'hFFFF;
    localparam logic [15:0] ERRADDR_ADDR = 16'hFFFE;
    localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: CPU data port, data-memory and IO-device signals of io_bus_ctrl.
//   master modport - the controller (drives mem_we, cpu_rdata, cpu_stall, dev_*, io_err)
//   slave modport  - the environment (drives cpu_*, mem_rdata, dev_ack, dev_rdata)
//   dev_rdata is flattened: device i occupies bits [16i+15:16i].
interface io_bus_ctrl_if #(
    parameter int unsigned DEV_SEL_BITS = 2
);
    localparam int unsigned NUM_DEV = 1 << DEV_SEL_BITS;

    logic [15:0]            cpu_addr;
    logic [15:0]            cpu_wdata;
    logic                   cpu_we;
    logic                   cpu_re;
    logic [15:0]            mem_rdata;
    logic                   mem_we;
    logic [15:0]            cpu_rdata;
    logic                   cpu_stall;
    logic                   dev_req;
    logic [NUM_DEV-1:0]     dev_sel;
    logic [11:0]            dev_addr;
    logic [15:0]            dev_wdata;
    logic                   dev_we;
    logic [NUM_DEV-1:0]     dev_ack;
    logic [16*NUM_DEV-1:0]  dev_rdata;
    logic                   io_err;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, dev_ack, dev_rdata,
        output mem_we, cpu_rdata, cpu_stall, dev_req, dev_sel, dev_addr, dev_wdata, dev_we,
               io_err
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, dev_ack, dev_rdata,
        input  mem_we, cpu_rdata, cpu_stall, dev_req, dev_sel, dev_addr, dev_wdata, dev_we,
               io_err
    );

endinterface

// File: rtl/io_timeout_ctr.sv
// io_timeout_ctr: clearable, enabled up-counter with an expiry flag.
//   clk, reset - clock, synchronous active-high reset
//   i_clr      - synchronous clear (to 0)
//   i_en       - count enable
//   o_expired  - counter currently equals TIMEOUT-1
module io_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expired = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: sequencing controller for the memory-mapped IO region (addr[15:14] == 2'b11).
//   clk, reset - clock, synchronous active-high reset
//   bus        - io_bus_ctrl_if.master: CPU port, data-memory strobe, device req/ack bus
// Non-IO traffic passes straight to data memory. IO accesses stall the CPU, run a req/ack
// handshake with the selected device (or hit the local registers at 0xFFF0-0xFFFF) and
// time out after TIMEOUT REQ cycles, setting the sticky io_err flag.
// Optional: define IO_ERR_CAPTURE_EN to capture the address of the first timed-out access,
// readable at 0xFFFE.
module io_bus_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DEV_SEL_BITS = 2,
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned TO_W         = 5
) (
    input logic          clk,
    input logic          reset,
    io_bus_ctrl_if.master bus
);

    localparam int unsigned NUM_DEV = 1 << DEV_SEL_BITS;
`ifdef IO_ERR_CAPTURE_EN
    localparam int unsigned ADDR_KEEP = 16;
`else
    // Only the device offset and select bits are ever needed downstream.
    localparam int unsigned ADDR_KEEP = 12 + DEV_SEL_BITS;
`endif

    io_state_e               r_state, w_state_next;
    logic [ADDR_KEEP-1:0]    r_addr;
    logic [15:0]             r_wdata;
    logic                    r_we;
    logic [15:0]             r_data;
    logic                    r_err;
`ifdef IO_ERR_CAPTURE_EN
    logic [15:0]             r_err_addr;
`endif

    logic                    w_io_hit, w_loc_hit, w_is_write;
    logic                    w_expired, w_ack, w_err_clr;
    logic                    w_stall, w_req, w_start, w_loc_acc, w_cnt_clr, w_cnt_en;
    logic                    w_done_ack, w_timeout;
    logic [DEV_SEL_BITS-1:0] w_sel_idx;
    logic [NUM_DEV-1:0]      w_dev_sel;
    logic [15:0]             w_dev_rdata_sel, w_loc_rdata;

    assign w_io_hit   = (bus.cpu_we | bus.cpu_re) & (bus.cpu_addr[15:14] == IO_REGION);
    assign w_loc_hit  = w_io_hit & (bus.cpu_addr[15:4] == LOC_BASE);
    assign w_is_write = bus.cpu_we;   // write wins when both strobes are high

    assign w_sel_idx       = r_addr[12 +: DEV_SEL_BITS];
    assign w_ack           = bus.dev_ack[w_sel_idx];
    assign w_dev_rdata_sel = bus.dev_rdata[{w_sel_idx, 4'b0000} +: 16];

    assign w_err_clr = w_loc_acc & w_is_write & (bus.cpu_addr == STAT_ADDR) & bus.cpu_wdata[15];

    always_comb begin
        w_loc_rdata = '0;
        if (bus.cpu_addr == STAT_ADDR) begin
            w_loc_rdata = {r_err, 15'b0};
        end
`ifdef IO_ERR_CAPTURE_EN
        else if (bus.cpu_addr == ERRADDR_ADDR) begin
            w_loc_rdata = r_err_addr;
        end
`endif
    end

    io_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout_ctr (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_cnt_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        w_dev_sel    = '0;
        w_start      = 1'b0;
        w_loc_acc    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_done_ack   = 1'b0;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_io_hit) begin
                    w_stall = 1'b1;
                    if (w_loc_hit) begin
                        w_loc_acc    = 1'b1;
                        w_state_next = StDone;
                    end else begin
                        w_start      = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = StReq;
                    end
                end
            end
            StReq: begin
                w_stall              = 1'b1;
                w_req                = 1'b1;
                w_dev_sel[w_sel_idx] = 1'b1;
                w_cnt_en             = 1'b1;
                // An ack in the expiry cycle takes precedence over the timeout.
                if (w_ack) begin
                    w_done_ack   = 1'b1;
                    w_state_next = StDone;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr  <= bus.cpu_addr[ADDR_KEEP-1:0];
                r_wdata <= bus.cpu_wdata;
                r_we    <= w_is_write;
            end
            if (w_loc_acc) begin
                r_data <= w_is_write ? 16'h0000 : w_loc_rdata;
            end else if (w_done_ack) begin
                r_data <= w_dev_rdata_sel;
            end else if (w_timeout) begin
                r_data <= TIMEOUT_DATA;
            end
            // Set beats clear, even though the FSM never asks for both at once.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef IO_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_addr <= '0;
        end else if (w_timeout && !r_err) begin
            r_err_addr <= r_addr;
        end else if (w_err_clr) begin
            r_err_addr <= '0;
        end
    end
`endif

    assign bus.mem_we    = bus.cpu_we & (bus.cpu_addr[15:14] != IO_REGION);
    assign bus.cpu_rdata = (r_state == StDone) ? r_data : bus.mem_rdata;
    assign bus.cpu_stall = w_stall;
    assign bus.dev_req   = w_req;
    assign bus.dev_sel   = w_dev_sel;
    assign bus.dev_addr  = r_addr[11:0];
    assign bus.dev_wdata = r_wdata;
    assign bus.dev_we    = r_we;
    assign bus.io_err    = r_err;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: self-checking bench for io_bus_ctrl.
// Pass-through vectors come from a table; IO accesses push their expected read data to a
// scoreboard queue that is popped in the cycle the stall drops.
module tb_io_bus_ctrl;

    localparam int unsigned DEV_SEL_BITS = 2;
    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned TO_W         = 5;

    logic clk;
    logic reset;

    io_bus_ctrl_if #(.DEV_SEL_BITS(DEV_SEL_BITS)) bus ();

    io_bus_ctrl #(
        .DEV_SEL_BITS (DEV_SEL_BITS),
        .TIMEOUT      (TIMEOUT),
        .TO_W         (TO_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        re;
        logic [15:0] mem_rdata;
        logic [15:0] exp_rdata;
        logic        exp_mem_we;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.cpu_we  = 1'b0;
        bus.cpu_re  = 1'b0;
        bus.dev_ack = '0;
    endtask

    // One CPU access into the IO region. ack_at = REQ cycle (1-based) on which ack_mask is
    // driven, 0 for never. exp_stall counts stalled cycles including the IDLE decode cycle.
    task automatic io_access(input string nm, input logic [15:0] a, input logic [15:0] wd,
                             input logic we, input logic re, input int ack_at,
                             input logic [3:0] ack_mask, input logic [3:0] exp_sel,
                             input logic [15:0] exp_rd, input int exp_stall);
        int  stalls;
        int  reqs;
        bit  done;
        logic [15:0] exp_pop;
        @(posedge clk); #1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.dev_ack   = '0;
        sb_q.push_back(exp_rd);
        stalls = 0;
        reqs   = 0;
        done   = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, " mem_we"}, {15'b0, bus.mem_we}, 16'h0000);
            if (bus.cpu_stall) begin
                stalls++;
                bus.dev_ack = '0;
                if (bus.dev_req) begin
                    reqs++;
                    if (reqs == 1) begin
                        chk({nm, " dev_sel"}, {12'b0, bus.dev_sel}, {12'b0, exp_sel});
                        chk({nm, " dev_addr"}, {4'b0, bus.dev_addr}, {4'b0, a[11:0]});
                        chk({nm, " dev_we"}, {15'b0, bus.dev_we}, {15'b0, we});
                        if (we) chk({nm, " dev_wdata"}, bus.dev_wdata, wd);
                    end
                    if (reqs == ack_at) bus.dev_ack = ack_mask;
                end
            end else begin
                done = 1'b1;
                exp_pop = sb_q.pop_front();
                chk({nm, " rdata"}, bus.cpu_rdata, exp_pop);
                chk({nm, " stalls"}, 16'(stalls), 16'(exp_stall));
                chk({nm, " req_cycles"}, 16'(reqs), 16'(exp_stall - 1));
                chk({nm, " done dev_req"}, {15'b0, bus.dev_req}, 16'h0000);
            end
        end
        if (!done) begin
            chk({nm, " completion within bound"}, 16'h0000, 16'h0001);
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        // Non-IO pass-through vectors, including IO-region address with no strobe.
        vecs[0] = '{16'h1234, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 16'h0055, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0000, 1'b0, 1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0};
        vecs[3] = '{16'hBFFF, 16'h7777, 1'b1, 1'b1, 16'h2222, 16'h2222, 1'b1, 1'b0};
        vecs[4] = '{16'hC000, 16'h9999, 1'b0, 1'b0, 16'h4321, 16'h4321, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA0A0, 16'hA0A0, 1'b0, 1'b0};

        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.dev_rdata = {16'h3333, 16'h2222, 16'h1111, 16'h5A5A};
        idle_bus();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset stall", {15'b0, bus.cpu_stall}, 16'h0000);
        chk("reset dev_req", {15'b0, bus.dev_req}, 16'h0000);
        chk("reset dev_sel", {12'b0, bus.dev_sel}, 16'h0000);
        chk("reset dev_addr", {4'b0, bus.dev_addr}, 16'h0000);
        chk("reset dev_wdata", bus.dev_wdata, 16'h0000);
        chk("reset dev_we", {15'b0, bus.dev_we}, 16'h0000);
        chk("reset io_err", {15'b0, bus.io_err}, 16'h0000);

        foreach (vecs[k]) begin
            @(posedge clk); #1;
            bus.cpu_addr  = vecs[k].addr;
            bus.cpu_wdata = vecs[k].wdata;
            bus.cpu_we    = vecs[k].we;
            bus.cpu_re    = vecs[k].re;
            bus.mem_rdata = vecs[k].mem_rdata;
            sb_q.push_back(vecs[k].exp_rdata);
            @(negedge clk);
            chk($sformatf("vec%0d rdata", k), bus.cpu_rdata, sb_q.pop_front());
            chk($sformatf("vec%0d mem_we", k), {15'b0, bus.mem_we}, {15'b0, vecs[k].exp_mem_we});
            chk($sformatf("vec%0d stall", k), {15'b0, bus.cpu_stall}, {15'b0, vecs[k].exp_stall});
        end
        @(posedge clk); #1;
        idle_bus();
        bus.mem_rdata = 16'hDEAD;

        io_access("store D010", 16'hD010, 16'hA5A5, 1'b1, 1'b0, 3, 4'b0010, 4'b0010,
                  16'h1111, 4);
        io_access("load C004", 16'hC004, 16'h0000, 1'b0, 1'b1, 1, 4'b0001, 4'b0001,
                  16'h5A5A, 2);
        // Non-selected acks must be ignored, so this access times out.
        io_access("timeout E000", 16'hE000, 16'h0000, 1'b0, 1'b1, 1, 4'b1011, 4'b0100,
                  16'hFFFF, TIMEOUT + 1);
        chk("io_err after timeout", {15'b0, bus.io_err}, 16'h0001);
        io_access("read stat", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 4'b0000, 4'b0000,
                  16'h8000, 1);
`ifdef IO_ERR_CAPTURE_EN
        io_access("read erraddr", 16'hFFFE, 16'h0000, 1'b0, 1'b1, 0, 4'b0000, 4'b0000,
                  16'hE000, 1);
`else
        io_access("read erraddr", 16'hFFFE, 16'h0000, 1'b0, 1'b1, 0, 4'b0000, 4'b0000,
                  16'h0000, 1);
`endif
        io_access("write FFF0", 16'hFFF0, 16'h8000, 1'b1, 1'b0, 0, 4'b0000, 4'b0000,
                  16'h0000, 1);
        chk("io_err after FFF0 write", {15'b0, bus.io_err}, 16'h0001);
        io_access("clear stat", 16'hFFFF, 16'h8000, 1'b1, 1'b1, 0, 4'b0000, 4'b0000,
                  16'h0000, 1);
        chk("io_err after clear", {15'b0, bus.io_err}, 16'h0000);
        io_access("read stat clr", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0, 4'b0000, 4'b0000,
                  16'h0000, 1);
        io_access("ack at expiry", 16'hF000, 16'h0000, 1'b0, 1'b1, TIMEOUT, 4'b1000,
                  4'b1000, 16'h3333, TIMEOUT + 1);
        chk("io_err after expiry ack", {15'b0, bus.io_err}, 16'h0000);

        // Set io_err again so the reset check below is meaningful.
        io_access("timeout D000", 16'hD000, 16'h0000, 1'b0, 1'b1, 0, 4'b0000, 4'b0010,
                  16'hFFFF, TIMEOUT + 1);
        chk("io_err set again", {15'b0, bus.io_err}, 16'h0001);

        // Reset in the middle of REQ.
        @(posedge clk); #1;
        bus.cpu_addr = 16'hD000;
        bus.cpu_re   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset dev_req", {15'b0, bus.dev_req}, 16'h0001);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_bus();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid-REQ reset dev_req", {15'b0, bus.dev_req}, 16'h0000);
        chk("mid-REQ reset dev_sel", {12'b0, bus.dev_sel}, 16'h0000);
        chk("mid-REQ reset stall", {15'b0, bus.cpu_stall}, 16'h0000);
        chk("mid-REQ reset io_err", {15'b0, bus.io_err}, 16'h0000);
        chk("mid-REQ reset rdata", bus.cpu_rdata, 16'hDEAD);
        io_access("post-reset C004", 16'hC004, 16'h0000, 1'b0, 1'b1, 2, 4'b0001, 4'b0001,
                  16'h5A5A, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
